// File: rtl/man_demod_if.sv
// Manchester decoder bus: raw line and enable in, recovered bit strobes and frame flags out.
interface man_demod_if #(
  parameter int NBITS_W = 8
);
  logic               in_enable;
  logic               in_data;
  logic               out_data;
  logic               out_valid;
  logic               out_sof;
  logic               out_eof;
  logic               out_err;
  logic               out_busy;
  logic [NBITS_W-1:0] out_nbits;

  modport master (
    output in_enable, in_data,
    input  out_data, out_valid, out_sof, out_eof, out_err, out_busy, out_nbits
  );

  modport slave (
    input  in_enable, in_data,
    output out_data, out_valid, out_sof, out_eof, out_err, out_busy, out_nbits
  );
endinterface

// File: rtl/man_demod.sv
// Manchester decoder (1 = high-then-low): strobes are registered, 3 clk after the line change.
// No backpressure: every strobe is a single unbuffered cycle the consumer must take.
module man_demod #(
  parameter int OSR     = 16,
  parameter int CNT_W   = 6,
  parameter int NBITS_W = 8
) (
  input  logic       clk,
  input  logic       in_reset,
  man_demod_if.slave bus
);
  localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(OSR / 4);
  localparam logic [CNT_W-1:0] WIN_MID = CNT_W'(3 * OSR / 4);
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(5 * OSR / 4);

  typedef enum logic [1:0] {HUNT, SOF, DATA} state_t;

  state_t             state;
  logic               sync1, sync2, sync3;
  logic [CNT_W-1:0]   cnt;
  logic               bnd_seen;
  logic               data_q, valid_q, sof_q, eof_q, err_q, busy_q;
  logic [NBITS_W-1:0] nbits_q;

  logic               line_edge, line_rise, line_fall;
  logic               mid_edge;
  logic [CNT_W-1:0]   cnt_next;
  logic [NBITS_W-1:0] nbits_next;

  assign line_edge  = sync2 ^ sync3;
  assign line_rise  = sync2 & ~sync3;
  assign line_fall  = ~sync2 & sync3;
  assign mid_edge   = line_edge && (cnt >= WIN_MID) && (cnt <= WIN_HI);
  assign cnt_next   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign nbits_next = (nbits_q == '1) ? nbits_q : nbits_q + 1'b1;

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state    <= HUNT;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      cnt      <= '0;
      bnd_seen <= 1'b0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      nbits_q  <= '0;
    end else begin
      sync1   <= bus.in_data;
      sync2   <= sync1;
      sync3   <= sync2;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;

      if (!bus.in_enable) begin
        // Disable overrides any strobe condition in the same cycle.
        state    <= HUNT;
        cnt      <= '0;
        bnd_seen <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            cnt      <= '0;
            bnd_seen <= 1'b0;
            if (line_rise) state <= SOF;
          end

          SOF: begin
            if (line_edge) begin
              cnt <= '0;
              if (line_fall && (cnt >= WIN_LO) && (cnt <= WIN_MID)) begin
                state    <= DATA;
                sof_q    <= 1'b1;
                busy_q   <= 1'b1;
                nbits_q  <= '0;
                bnd_seen <= 1'b0;
              end else begin
                state <= HUNT;
              end
            end else if (cnt >= WIN_MID) begin
              state <= HUNT;
              cnt   <= '0;
            end else begin
              cnt <= cnt_next;
            end
          end

          DATA: begin
            if (mid_edge) begin
              // Falling mid-bit edge encodes a '1'.
              data_q   <= line_fall;
              valid_q  <= 1'b1;
              nbits_q  <= nbits_next;
              cnt      <= '0;
              bnd_seen <= 1'b0;
            end else if (line_edge && (cnt < WIN_MID) && bnd_seen) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= HUNT;
              cnt    <= '0;
            end else if (cnt >= WIN_HI) begin
              // No mid-bit edge in time: a low line is a clean end, a high line is stuck.
              err_q  <= sync2;
              eof_q  <= ~sync2;
              busy_q <= 1'b0;
              state  <= HUNT;
              cnt    <= '0;
            end else begin
              cnt <= cnt_next;
              if (line_edge) bnd_seen <= 1'b1;
            end
          end

          default: begin
            state <= HUNT;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eof   = eof_q;
  assign bus.out_err   = err_q;
  assign bus.out_busy  = busy_q;
  assign bus.out_nbits = nbits_q;
endmodule
